// File: rtl/spi_master_ctrl_if.sv
// Host-side request/response bundle for spi_master_ctrl.
// master = host view, slave = controller view.
interface spi_master_ctrl_if;
  logic       start;
  logic [9:0] cmd_word;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output start, cmd_word,
    input  busy, done, rd_data, rd_valid
  );

  modport slave (
    input  start, cmd_word,
    output busy, done, rd_data, rd_valid
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Framed SPI master on the system clock: select, command bit, 10-bit word, optional 8-bit read-back.
// Optional abort input enabled by defining SPI_MASTER_ABORT_EN.
module spi_master_ctrl #(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned GAP        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_master_ctrl_if.slave     host,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CMD, S_SHIFT, S_TURN, S_CAPTURE, S_END, S_GAP
  } state_t;

  state_t     state, state_nx;
  logic [9:0] sr;
  logic       is_rd;
  logic [3:0] cnt;
  logic [2:0] tcnt;
  logic [7:0] rx_sr;
  logic [7:0] rd_data_q;
  logic       busy, done, rd_valid;
  logic       abort_req;

`ifdef SPI_MASTER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    SS_n     = 1'b0;
    MOSI     = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    rd_valid = 1'b0;
    case (state)
      S_IDLE: begin
        SS_n = 1'b1;
        busy = 1'b0;
        if (host.start) state_nx = S_SELECT;
      end
      S_SELECT: begin
        MOSI     = sr[9];
        state_nx = S_CMD;
      end
      S_CMD: begin
        MOSI     = sr[9];
        state_nx = S_SHIFT;
      end
      // sr shifts left during SHIFT, so sr[9] always carries bit 9-cnt
      S_SHIFT: begin
        MOSI = sr[9];
        if (cnt == 4'd9) state_nx = is_rd ? S_TURN : S_END;
      end
      S_TURN: begin
        if (tcnt == 3'(TURNAROUND - 1)) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cnt == 4'd7) state_nx = S_END;
      end
      S_END: begin
        done     = 1'b1;
        rd_valid = is_rd;
        state_nx = S_GAP;
      end
      S_GAP: begin
        SS_n = 1'b1;
        if (tcnt == 3'(GAP - 1)) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (abort_req && state != S_IDLE && state != S_GAP) begin
      state_nx = S_GAP;
      done     = 1'b0;
      rd_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sr        <= '0;
      is_rd     <= 1'b0;
      cnt       <= '0;
      tcnt      <= '0;
      rx_sr     <= '0;
      rd_data_q <= '0;
    end else begin
      state <= state_nx;

      if (state == S_IDLE && host.start) begin
        sr    <= host.cmd_word;
        is_rd <= (host.cmd_word[9:8] == 2'b11);
      end else if (state == S_SHIFT) begin
        sr <= {sr[8:0], 1'b0};
      end

      if (state_nx != state) begin
        cnt  <= '0;
        tcnt <= '0;
      end else begin
        if (state == S_SHIFT || state == S_CAPTURE) cnt  <= cnt + 4'd1;
        if (state == S_TURN  || state == S_GAP)     tcnt <= tcnt + 3'd1;
      end

      if (state == S_CAPTURE) rx_sr <= {rx_sr[6:0], MISO};

      if (state == S_END && is_rd && !abort_req) rd_data_q <= rx_sr;
    end
  end

  assign host.busy     = busy;
  assign host.done     = done;
  assign host.rd_valid = rd_valid;
  assign host.rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: frame lengths, MOSI order, read capture, gaps and reset.
// Define SPI_MASTER_ABORT_EN to also exercise the abort path.
module tb_spi_master_ctrl;
  localparam int unsigned TA = 2;
  localparam int unsigned GP = 1;

  logic clk;
  logic rst_n;
  logic ss_n, mosi, miso;
`ifdef SPI_MASTER_ABORT_EN
  logic abort;
`endif

  int total = 0;
  int bad   = 0;

  spi_master_ctrl_if hif ();

  spi_master_ctrl #(.TURNAROUND(TA), .GAP(GP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (hif),
    .SS_n  (ss_n),
    .MOSI  (mosi),
    .MISO  (miso)
`ifdef SPI_MASTER_ABORT_EN
    ,
    .abort (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from IDLE; slave model drives miso_byte MSB-first in the CAPTURE window.
  task automatic run_frame(input logic [9:0] cmd, input logic [7:0] miso_byte, input int abort_at,
                           output int low, output logic [11:0] mosi_seq, output int ndone,
                           output int done_at, output int nvalid, output int valid_at, output int gap);
    int k;
    low = 0; mosi_seq = '0; ndone = 0; done_at = 0; nvalid = 0; valid_at = 0; gap = 0;
    for (int w = 0; w < 20 && hif.busy; w++) @(negedge clk);
    hif.cmd_word = cmd;
    hif.start    = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      hif.start = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
      abort = 1'b0;
`endif
      if (!ss_n) begin
        low++;
        if (low <= 12) mosi_seq[12 - low] = mosi;
        k = low - (12 + int'(TA));
        if (k >= 1 && k <= 8) miso = miso_byte[8 - k];
        else miso = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
        if (low == abort_at) abort = 1'b1;
`endif
      end else if (low > 0) begin
        break;
      end
      if (hif.done)     begin ndone++;  done_at  = low; end
      if (hif.rd_valid) begin nvalid++; valid_at = low; end
    end
    miso = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!hif.busy) break;
      gap++;
      @(negedge clk);
    end
    if (abort_at < 0) $display("unused abort_at");
  endtask

  int low, ndone, done_at, nvalid, valid_at, gap;
  logic [11:0] mseq;
  int prev, falls, rises, t0, t1, t2, nd, cyc;

  initial begin
    rst_n        = 1'b0;
    hif.start    = 1'b1;
    hif.cmd_word = 10'h3FF;
    miso         = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    abort        = 1'b0;
`endif

    // reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ss_n",    32'(ss_n),        32'd1);
      chk("rst_mosi",    32'(mosi),        32'd0);
      chk("rst_busy",    32'(hif.busy),    32'd0);
      chk("rst_rd_data", 32'(hif.rd_data), 32'h00);
    end
    hif.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("post_rst_ss_n", 32'(ss_n),     32'd1);
    chk("post_rst_busy", 32'(hif.busy), 32'd0);
    chk("post_rst_done", 32'(hif.done), 32'd0);

    // write address
    run_frame(10'b00_1010_0101, 8'h00, 0, low, mseq, ndone, done_at, nvalid, valid_at, gap);
    chk("wa_low",     32'(low),     32'd13);
    chk("wa_mosi",    32'(mseq),    32'h0A5);
    chk("wa_ndone",   32'(ndone),   32'd1);
    chk("wa_done_at", 32'(done_at), 32'd13);
    chk("wa_nvalid",  32'(nvalid),  32'd0);
    chk("wa_gap",     32'(gap),     32'(GP));

    // write data
    run_frame(10'b01_1111_0000, 8'h00, 0, low, mseq, ndone, done_at, nvalid, valid_at, gap);
    chk("wd_low",    32'(low),    32'd13);
    chk("wd_mosi",   32'(mseq),   32'h1F0);
    chk("wd_nvalid", 32'(nvalid), 32'd0);

    // read address is a plain 13-cycle frame
    run_frame(10'b10_0101_1010, 8'hFF, 0, low, mseq, ndone, done_at, nvalid, valid_at, gap);
    chk("ra_low",     32'(low),         32'd13);
    chk("ra_mosi",    32'(mseq),        32'hE5A);
    chk("ra_nvalid",  32'(nvalid),      32'd0);
    chk("ra_rd_data", 32'(hif.rd_data), 32'h00);

    // read data, two different replies
    run_frame(10'b11_1000_0001, 8'h5A, 0, low, mseq, ndone, done_at, nvalid, valid_at, gap);
    chk("rd1_low",      32'(low),         32'd23);
    chk("rd1_mosi",     32'(mseq),        32'hF81);
    chk("rd1_valid_at", 32'(valid_at),    32'd23);
    chk("rd1_rd_data",  32'(hif.rd_data), 32'h5A);

    run_frame(10'b11_0000_0000, 8'hC3, 0, low, mseq, ndone, done_at, nvalid, valid_at, gap);
    chk("rd2_low",      32'(low),         32'd23);
    chk("rd2_mosi",     32'(mseq),        32'hF00);
    chk("rd2_ndone",    32'(ndone),       32'd1);
    chk("rd2_done_at",  32'(done_at),     32'd23);
    chk("rd2_nvalid",   32'(nvalid),      32'd1);
    chk("rd2_valid_at", 32'(valid_at),    32'd23);
    chk("rd2_rd_data",  32'(hif.rd_data), 32'hC3);
    chk("rd2_gap",      32'(gap),         32'(GP));

    // rd_data holds across a write frame
    run_frame(10'b00_0000_0001, 8'h00, 0, low, mseq, ndone, done_at, nvalid, valid_at, gap);
    chk("hold_rd_data", 32'(hif.rd_data), 32'hC3);

    // back-to-back with start held: high time is GAP plus the accepting IDLE cycle
    hif.cmd_word = 10'b00_1010_0101;
    hif.start    = 1'b1;
    prev = 1; falls = 0; rises = 0; t0 = 0; t1 = 0; t2 = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (prev == 1 && !ss_n) begin
        falls++;
        if (falls == 1) t0 = c; else if (falls == 2) t2 = c;
      end
      if (prev == 0 && ss_n) begin
        rises++;
        if (rises == 1) t1 = c;
      end
      prev = int'(ss_n);
      if (rises == 2) break;
    end
    chk("b2b_rises",    32'(rises),   32'd2);
    chk("b2b_low",      32'(t1 - t0), 32'd13);
    chk("b2b_high",     32'(t2 - t1), 32'(GP + 1));
    chk("b2b_gap_busy", 32'(hif.busy), 32'd1);
    // start stays high through the GAP edge, then drops in IDLE: nothing may be queued
    @(negedge clk);
    hif.start = 1'b0;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!ss_n || hif.busy) nd++;
    end
    chk("b2b_no_queue", 32'(nd), 32'd0);

    // async reset in SHIFT cycle 5 (low cycle 7)
    hif.cmd_word = 10'b01_0110_1001;
    hif.start    = 1'b1;
    cyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      hif.start = 1'b0;
      if (!ss_n) cyc++;
      if (cyc == 7) break;
    end
    chk("mid_rst_in_frame", 32'(ss_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", 32'(ss_n),     32'd1);
    chk("mid_rst_mosi", 32'(mosi),     32'd0);
    chk("mid_rst_busy", 32'(hif.busy), 32'd0);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (hif.done) nd++;
    end
    chk("mid_rst_no_done", 32'(nd), 32'd0);
    rst_n = 1'b1;
    run_frame(10'b00_1010_0101, 8'h00, 0, low, mseq, ndone, done_at, nvalid, valid_at, gap);
    chk("fresh_low",     32'(low),     32'd13);
    chk("fresh_mosi",    32'(mseq),    32'h0A5);
    chk("fresh_done_at", 32'(done_at), 32'd13);

`ifdef SPI_MASTER_ABORT_EN
    run_frame(10'b11_0000_0000, 8'hC3, 0, low, mseq, ndone, done_at, nvalid, valid_at, gap);
    chk("ab_pre_rd_data", 32'(hif.rd_data), 32'hC3);
    // abort raised in CAPTURE cycle 3 = low cycle 12+TA+3
    run_frame(10'b11_0000_0000, 8'h3C, 12 + int'(TA) + 3, low, mseq, ndone, done_at, nvalid, valid_at, gap);
    chk("ab_low",     32'(low),         32'(12 + TA + 3));
    chk("ab_ndone",   32'(ndone),       32'd0);
    chk("ab_nvalid",  32'(nvalid),      32'd0);
    chk("ab_rd_data", 32'(hif.rd_data), 32'hC3);
    chk("ab_gap",     32'(gap),         32'(GP));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
